// File: rtl/alu_ctrl_if.sv
// Command/response handshake between the CPU control logic and the ALU sequencer.
// master = command initiator and response consumer, slave = alu_ctrl.
interface alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_shift;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shift, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shift, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_ctrl.sv
// Sequences one ALU operation per command over the ALU's shared bus and
// returns the captured result/carry on a valid/ready response.
module alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_if.slave        host,
  output logic [WIDTH-1:0] alu_bus_out,
  input  logic [WIDTH-1:0] alu_bus_in,
  input  logic             alu_carry_in,
  output logic             alu_enable,
  output logic             rega_enable,
  output logic             regb_enable,
  output logic             rega_write_enable,
  output logic             regb_write_enable,
  output logic             mul_enable,
  output logic             sub_enable,
  output logic             shift_enable,
  output logic [2:0]       shift_pos
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] READ   = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_RDA = 3'd4;

  logic [2:0]       state, next_state;
  logic [2:0]       op_q, shift_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cmd_ready_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_carry_q, rsp_err_q;
  logic             accept;

  assign accept = (state == IDLE) && host.cmd_valid && cmd_ready_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (host.cmd_op <= OP_RDA) ? LOAD_A : RESP;
      LOAD_A: begin
        if (op_q == OP_ADD || op_q == OP_SUB) next_state = LOAD_B;
        else if (op_q == OP_RDA)              next_state = READ;
        else                                  next_state = EXEC;
      end
      LOAD_B:  next_state = EXEC;
      EXEC:    next_state = READ;
      READ:    next_state = RESP;
      RESP:    if (host.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      op_q        <= '0;
      shift_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= next_state;
      // Registered so ready stays low through reset and rises one edge later.
      cmd_ready_q <= (next_state == IDLE);
      if (accept) begin
        op_q    <= host.cmd_op;
        shift_q <= host.cmd_shift;
        a_q     <= host.cmd_a;
        b_q     <= host.cmd_b;
        if (host.cmd_op > OP_RDA) begin
          rsp_data_q  <= '1;
          rsp_carry_q <= 1'b0;
          rsp_err_q   <= 1'b1;
        end
      end
      if (state == READ) begin
        rsp_data_q  <= alu_bus_in;
        rsp_carry_q <= (op_q == OP_RDA) ? 1'b0 : alu_carry_in;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  // ALU controls decode only from registered state and the captured opcode.
  always_comb begin
    alu_bus_out       = '0;
    alu_enable        = 1'b0;
    rega_enable       = 1'b0;
    regb_enable       = 1'b0;
    rega_write_enable = 1'b0;
    regb_write_enable = 1'b0;
    mul_enable        = 1'b0;
    sub_enable        = 1'b0;
    shift_enable      = 1'b0;
    shift_pos         = '0;
    case (state)
      LOAD_A: begin
        rega_write_enable = 1'b1;
        alu_bus_out       = a_q;
      end
      LOAD_B: begin
        regb_write_enable = 1'b1;
        alu_bus_out       = b_q;
      end
      EXEC, READ: begin
        // Operation selects stay asserted into READ so the ALU output is settled.
        if (state == READ) begin
          if (op_q == OP_RDA) rega_enable = 1'b1;
          else                alu_enable  = 1'b1;
        end
        sub_enable   = (op_q == OP_SUB);
        mul_enable   = (op_q == OP_MUL);
        shift_enable = (op_q == OP_SHL);
        if (op_q == OP_SHL) shift_pos = shift_q;
      end
      default: ;
    endcase
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = (state == RESP);
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_carry = rsp_carry_q;
  assign host.rsp_err   = rsp_err_q;

endmodule
